// File: rtl/dnn_pkg.sv
// Shared types and constants for the accumulator-drain datapath.
package dnn_pkg;

    localparam int DEF_WIDTH_IN  = 16;
    localparam int DEF_WIDTH_OUT = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } drain_state_e;

    function automatic int act_max(input int width_out);
        return (1 << (width_out - 1)) - 1;
    endfunction

    localparam int ACT_MAX = act_max(DEF_WIDTH_OUT);

endpackage

// File: rtl/act_packer.sv
// ReLU/int8 saturation, lane packing register and a one-word output register
// with a valid/ready handshake toward the activation buffer.
module act_packer
    import dnn_pkg::*;
#(
    parameter int WIDTH_IN  = DEF_WIDTH_IN,
    parameter int WIDTH_OUT = DEF_WIDTH_OUT,
    parameter int LANES     = 4,
    parameter int CNT_W     = 3,
    parameter int SAT_MAX   = ACT_MAX
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic signed [WIDTH_IN-1:0]          in_data,
    input  logic                                flush,
    input  logic                                act_wr_ready,
    output logic                                act_wr_en,
    output logic [LANES-1:0][WIDTH_OUT-1:0]     act_wr_data,
    output logic [LANES-1:0]                    act_wr_mask,
    output logic                                wr_accept,
    output logic [CNT_W-1:0]                    fill_next,
    output logic                                empty_next
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic signed [WIDTH_IN-1:0] ZERO_IN = '0;
    localparam logic signed [WIDTH_IN-1:0] SAT_IN  = WIDTH_IN'(SAT_MAX);

    logic [LANES-1:0][WIDTH_OUT-1:0] lanes_q, lanes_d, lanes_tmp;
    logic [CNT_W-1:0]                fill_q, fill_d, fill_tmp;
    logic                            out_vld_q, out_vld_d;
    logic [LANES-1:0][WIDTH_OUT-1:0] out_data_q, out_data_d;
    logic [LANES-1:0]                out_mask_q, out_mask_d;
    logic [WIDTH_OUT-1:0]            act;
    logic                            out_free;
    logic                            move;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        act = in_data[WIDTH_OUT-1:0];
        if (in_data <= ZERO_IN) begin
            act = '0;
        end else if (in_data > SAT_IN) begin
            act = WIDTH_OUT'(SAT_MAX);
        end
    end

    always_comb begin
        lanes_tmp  = lanes_q;
        fill_tmp   = fill_q;
        lanes_d    = lanes_q;
        fill_d     = fill_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_mask_d = out_mask_q;

        if (in_valid) begin
            lanes_tmp[fill_q[LANE_W-1:0]] = act;
            fill_tmp = fill_q + CNT_W'(1);
        end

        wr_accept = out_vld_q && act_wr_ready;
        out_free  = !out_vld_q || act_wr_ready;
        move      = out_free && ((fill_tmp == CNT_W'(LANES)) || (flush && fill_tmp != '0));

        if (wr_accept) begin
            out_vld_d = 1'b0;
        end

        // Clearing the lanes on every move keeps unused lanes of a partial word at zero.
        if (move) begin
            out_vld_d  = 1'b1;
            out_data_d = lanes_tmp;
            for (int i = 0; i < LANES; i++) begin
                out_mask_d[i] = (CNT_W'(i) < fill_tmp);
            end
            lanes_d = '0;
            fill_d  = '0;
        end else begin
            lanes_d = lanes_tmp;
            fill_d  = fill_tmp;
        end

        fill_next  = fill_d;
        empty_next = (fill_d == '0) && !out_vld_d;
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the lane register is a handful of flops, not a RAM, so it is reset with everything else.
            lanes_q    <= '0;
            fill_q     <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_mask_q <= '0;
        end else begin
            lanes_q    <= lanes_d;
            fill_q     <= fill_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_mask_q <= out_mask_d;
        end
    end

    assign act_wr_en   = out_vld_q;
    assign act_wr_data = out_data_q;
    assign act_wr_mask = out_mask_q;

endmodule

// File: rtl/act_drain_ctrl.sv
// Drains signed accumulator results through ReLU/saturation and writes them
// LANES-at-a-time into the activation buffer.
module act_drain_ctrl
    import dnn_pkg::*;
#(
    parameter int WIDTH_IN  = DEF_WIDTH_IN,
    parameter int WIDTH_OUT = DEF_WIDTH_OUT,
    parameter int LANES     = 4,
    parameter int ADDR_W    = 10,
    parameter int RD_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_W:0]               len,
    input  logic [ADDR_W-1:0]             src_base,
    input  logic [ADDR_W-1:0]             dst_base,
    output logic                          busy,
    output logic                          done,
    output logic                          acc_rd_en,
    output logic [ADDR_W-1:0]             acc_rd_addr,
    input  logic signed [WIDTH_IN-1:0]    acc_rd_data,
    output logic                          act_wr_en,
    output logic [ADDR_W-1:0]             act_wr_addr,
    output logic [LANES*WIDTH_OUT-1:0]    act_wr_data,
    output logic [LANES-1:0]              act_wr_mask,
    input  logic                          act_wr_ready
);

    localparam int CNT_W = $clog2(LANES + 1);

    drain_state_e      state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   issued_q, issued_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              ret;
    logic              rd_en;
    logic              flush_req;
    logic              wr_accept;
    logic              pk_empty_next;
    logic [CNT_W-1:0]  fill_next;
    logic [CNT_W:0]    occ;

    act_packer #(
        .WIDTH_IN  (WIDTH_IN),
        .WIDTH_OUT (WIDTH_OUT),
        .LANES     (LANES),
        .CNT_W     (CNT_W),
        .SAT_MAX   (act_max(WIDTH_OUT))
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (ret),
        .in_data      (acc_rd_data),
        .flush        (flush_req),
        .act_wr_ready (act_wr_ready),
        .act_wr_en    (act_wr_en),
        .act_wr_data  (act_wr_data),
        .act_wr_mask  (act_wr_mask),
        .wr_accept    (wr_accept),
        .fill_next    (fill_next),
        .empty_next   (pk_empty_next)
    );

    always_comb begin
        ret       = vld_q[RD_LAT-1];
        flush_req = (state_q == FLUSH) && (inflight_q == '0);

        // Occupancy after this cycle's return and any word leaving the lanes frees credit immediately.
        occ   = {1'b0, inflight_q} - (CNT_W+1)'(ret) + {1'b0, fill_next};
        rd_en = (state_q == RUN) && (issued_q < len_q) && (occ < (CNT_W+1)'(LANES));

        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        busy_d     = busy_q;
        inflight_d = inflight_q + CNT_W'(rd_en) - CNT_W'(ret);
        vld_d      = vld_q << 1;
        vld_d[0]   = rd_en;

        if (rd_en) begin
            issued_d  = issued_q + (ADDR_W+1)'(1);
            rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
        if (wr_accept) begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = len;
                    issued_d  = '0;
                    rd_addr_d = src_base;
                    wr_addr_d = dst_base;
                    if (len == '0) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (rd_en && (issued_q + (ADDR_W+1)'(1) == len_q)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if ((inflight_q == '0) && pk_empty_next) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            inflight_q <= '0;
            vld_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            inflight_q <= inflight_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign acc_rd_en   = rd_en;
    assign acc_rd_addr = rd_addr_q;
    assign act_wr_addr = wr_addr_q;

endmodule

// File: tb/tb_act_drain_ctrl.sv
// Directed bench for act_drain_ctrl: table of drains plus hand-written
// sequences for length zero, backpressure, mid-drain reset and stray start.
module tb_act_drain_ctrl;

    localparam int ADDR_W = 10;
    localparam int LANES  = 4;
    localparam int WI     = 16;
    localparam int WO     = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [ADDR_W:0]        len_i = '0;
    logic [ADDR_W-1:0]      src_i = '0;
    logic [ADDR_W-1:0]      dst_i = '0;
    logic                   busy, done;
    logic                   acc_rd_en;
    logic [ADDR_W-1:0]      acc_rd_addr;
    logic signed [WI-1:0]   acc_rd_data;
    logic                   act_wr_en;
    logic [ADDR_W-1:0]      act_wr_addr;
    logic [LANES*WO-1:0]    act_wr_data;
    logic [LANES-1:0]       act_wr_mask;
    logic                   act_wr_ready = 1'b1;

    always #5 clk = ~clk;

    act_drain_ctrl #(
        .WIDTH_IN  (WI),
        .WIDTH_OUT (WO),
        .LANES     (LANES),
        .ADDR_W    (ADDR_W),
        .RD_LAT    (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len_i),
        .src_base     (src_i),
        .dst_base     (dst_i),
        .busy         (busy),
        .done         (done),
        .acc_rd_en    (acc_rd_en),
        .acc_rd_addr  (acc_rd_addr),
        .acc_rd_data  (acc_rd_data),
        .act_wr_en    (act_wr_en),
        .act_wr_addr  (act_wr_addr),
        .act_wr_data  (act_wr_data),
        .act_wr_mask  (act_wr_mask),
        .act_wr_ready (act_wr_ready)
    );

    // Accumulator SRAM model with one cycle of read latency.
    logic [WI-1:0] mem [1024];
    logic [WI-1:0] rd_q = '0;
    always @(posedge clk) begin
        if (acc_rd_en) rd_q <= mem[acc_rd_addr];
    end
    assign acc_rd_data = rd_q;

    // Monitor: logs accepted writes, read strobes and done pulses.
    int          cyc = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int          last_wr_cyc = 0, done_cyc = 0;
    logic [ADDR_W-1:0]   wr_addr_log [256];
    logic [LANES*WO-1:0] wr_data_log [256];
    logic [LANES-1:0]    wr_mask_log [256];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (act_wr_en && act_wr_ready && wr_cnt < 256) begin
            wr_addr_log[wr_cnt] <= act_wr_addr;
            wr_data_log[wr_cnt] <= act_wr_data;
            wr_mask_log[wr_cnt] <= act_wr_mask;
            wr_cnt      <= wr_cnt + 1;
            last_wr_cyc <= cyc;
        end
        if (acc_rd_en) rd_cnt <= rd_cnt + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    typedef struct {
        int          len;
        int          src;
        int          dst;
        int          din [12];
        int          nw;
        logic [31:0] wd [3];
        logic [3:0]  wm [3];
    } vec_t;

    vec_t vecs [6];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    function automatic logic [63:0] outs();
        return {4'b0, acc_rd_en, act_wr_en, busy, done, acc_rd_addr, act_wr_addr,
                act_wr_data, act_wr_mask};
    endfunction

    task automatic start_drain(input int l, input int s, input int d);
        @(posedge clk);
        #1;
        start = 1'b1;
        len_i = (ADDR_W+1)'(l);
        src_i = ADDR_W'(s);
        dst_i = ADDR_W'(d);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (done_cnt != d0) break;
        end
        check({name, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic preload(input int vi);
        for (int i = 0; i < vecs[vi].len; i++) begin
            mem[(vecs[vi].src + i) % 1024] = WI'(vecs[vi].din[i]);
        end
    endtask

    task automatic check_result(input string name, input int vi, input int d0,
                                input int w0, input int r0);
        repeat (10) @(posedge clk);
        check({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        check({name, "_rd_count"}, 64'(rd_cnt - r0), 64'(vecs[vi].len));
        check({name, "_wr_count"}, 64'(wr_cnt - w0), 64'(vecs[vi].nw));
        check({name, "_done_lat"}, 64'(done_cyc), 64'(last_wr_cyc + 1));
        check({name, "_busy_end"}, 64'(busy), 64'd0);
        for (int k = 0; k < vecs[vi].nw; k++) begin
            check($sformatf("%s_w%0d_addr", name, k), 64'(wr_addr_log[w0 + k]),
                  64'((vecs[vi].dst + k) % 1024));
            check($sformatf("%s_w%0d_data", name, k), 64'(wr_data_log[w0 + k]), 64'(vecs[vi].wd[k]));
            check($sformatf("%s_w%0d_mask", name, k), 64'(wr_mask_log[w0 + k]), 64'(vecs[vi].wm[k]));
        end
    endtask

    task automatic run_vec(input int vi, input bit stray);
        int d0, w0, r0;
        string name;
        name = $sformatf("v%0d", vi);
        preload(vi);
        d0 = done_cnt;
        w0 = wr_cnt;
        r0 = rd_cnt;
        start_drain(vecs[vi].len, vecs[vi].src, vecs[vi].dst);
        @(negedge clk);
        check({name, "_first_rd"}, 64'({busy, acc_rd_en}), 64'b11);
        if (stray) begin
            @(posedge clk);
            #1;
            start = 1'b1;
            len_i = (ADDR_W+1)'(4);
            src_i = '0;
            dst_i = '0;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done(name, d0, 200);
        check_result(name, vi, d0, w0, r0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, w0, r0, rd_win;
        logic last_rd;

        vecs[0].len = 4; vecs[0].src = 0; vecs[0].dst = 5;
        vecs[0].din = '{0:5, 1:-3, 2:200, 3:127, default:0};
        vecs[0].nw  = 1;
        vecs[0].wd  = '{0:32'h7F7F_0005, default:32'h0};
        vecs[0].wm  = '{0:4'b1111, default:4'h0};

        vecs[1].len = 6; vecs[1].src = 16; vecs[1].dst = 100;
        vecs[1].din = '{0:1, 1:2, 2:3, 3:4, 4:5, 5:6, default:0};
        vecs[1].nw  = 2;
        vecs[1].wd  = '{0:32'h0403_0201, 1:32'h0000_0605, default:32'h0};
        vecs[1].wm  = '{0:4'b1111, 1:4'b0011, default:4'h0};

        vecs[2].len = 4; vecs[2].src = 40; vecs[2].dst = 7;
        vecs[2].din = '{0:-32768, 1:0, 2:1, 3:32767, default:0};
        vecs[2].nw  = 1;
        vecs[2].wd  = '{0:32'h7F01_0000, default:32'h0};
        vecs[2].wm  = '{0:4'b1111, default:4'h0};

        vecs[3].len = 5; vecs[3].src = 1022; vecs[3].dst = 1023;
        vecs[3].din = '{0:128, 1:-1, 2:126, 3:127, 4:50, default:0};
        vecs[3].nw  = 2;
        vecs[3].wd  = '{0:32'h7F7E_007F, 1:32'h0000_0032, default:32'h0};
        vecs[3].wm  = '{0:4'b1111, 1:4'b0001, default:4'h0};

        vecs[4].len = 8; vecs[4].src = 200; vecs[4].dst = 300;
        vecs[4].din = '{0:10, 1:11, 2:12, 3:13, 4:14, 5:15, 6:16, 7:17, default:0};
        vecs[4].nw  = 2;
        vecs[4].wd  = '{0:32'h0D0C_0B0A, 1:32'h1110_0F0E, default:32'h0};
        vecs[4].wm  = '{0:4'b1111, 1:4'b1111, default:4'h0};

        vecs[5].len = 12; vecs[5].src = 500; vecs[5].dst = 600;
        for (int i = 0; i < 12; i++) vecs[5].din[i] = 10 + i;
        vecs[5].nw  = 3;
        vecs[5].wd  = '{32'h0D0C_0B0A, 32'h1110_0F0E, 32'h1514_1312};
        vecs[5].wm  = '{4'b1111, 4'b1111, 4'b1111};

        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 64'd0);
        rst = 1'b0;

        // Table-driven drains.
        for (int vi = 0; vi < 4; vi++) run_vec(vi, 1'b0);

        // Start pulsed while running is ignored.
        run_vec(4, 1'b1);

        // Zero-length drain.
        d0 = done_cnt;
        w0 = wr_cnt;
        r0 = rd_cnt;
        start_drain(0, 3, 3);
        @(negedge clk);
        check("len0_first_cycle", 64'({done, busy, acc_rd_en, act_wr_en}), 64'b1000);
        @(negedge clk);
        check("len0_done_one_cycle", 64'(done), 64'd0);
        repeat (5) @(posedge clk);
        check("len0_no_rd", 64'(rd_cnt - r0), 64'd0);
        check("len0_no_wr", 64'(wr_cnt - w0), 64'd0);
        check("len0_done_once", 64'(done_cnt - d0), 64'd1);

        // Backpressure: hold ready low while word 0 is pending.
        act_wr_ready = 1'b0;
        preload(5);
        d0 = done_cnt;
        w0 = wr_cnt;
        r0 = rd_cnt;
        start_drain(vecs[5].len, vecs[5].src, vecs[5].dst);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (act_wr_en) break;
        end
        check("bp_pending", 64'(act_wr_en), 64'd1);
        rd_win  = 0;
        last_rd = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("bp_hold_%0d", k), 64'({act_wr_en, act_wr_data}),
                  64'({1'b1, vecs[5].wd[0]}));
            rd_win  = rd_win + int'(acc_rd_en);
            last_rd = acc_rd_en;
        end
        check("bp_rd_window_le_lanes", 64'(rd_win <= LANES), 64'd1);
        check("bp_reads_stalled", 64'(last_rd), 64'd0);
        @(posedge clk);
        #1;
        act_wr_ready = 1'b1;
        wait_done("bp", d0, 200);
        check_result("bp", 5, d0, w0, r0);

        // Reset in the middle of a long drain, then a clean drain.
        d0 = done_cnt;
        start_drain(16, 0, 50);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", outs(), 64'd0);
        @(negedge clk);
        check("rst_mid_hold", outs(), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        check("rst_no_done", 64'(done_cnt - d0), 64'd0);
        check("rst_idle_outputs", 64'({busy, acc_rd_en, act_wr_en}), 64'd0);
        run_vec(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
